// File: rtl/ps2_zx_keyboard.sv
// PS/2 scan-code set 2 receiver and decoder driving the ZX 8x5 key matrix,
// Kempston joystick bits and the magic/reset hotkey pulses.
module ps2_zx_keyboard #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic [7:0] kempston_data,
  output logic       key_magic,
  output logic       key_reset,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, RECV} rx_state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall, fall_dat;

  rx_state_t     state;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [10:0]   full;
  logic [TW-1:0] timer;
  logic          byte_stb, rx_err;
  logic [7:0]    byte_data;

  logic          ext, brk;
  logic [39:0]   key_m, pressed;
  logic          lshift, rshift, bksp, alt_l, alt_r, ctrl_l, ctrl_r;
  logic          joy_up, joy_down, joy_left, joy_right;
  logic [6:0]    slot;
  logic [4:0]    col_hit;

  // Synchroniser plus level filter; idle-high reset values avoid a spurious edge.
  always_ff @(posedge clk28) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      fall_dat <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
        fall_dat <= dat_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // full[0]=start, full[8:1]=data, full[9]=parity, full[10]=stop
  assign full = {fall_dat, sr};

  always_ff @(posedge clk28) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      timer     <= '0;
      byte_stb  <= 1'b0;
      byte_data <= '0;
      rx_err    <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (fall) begin
            sr      <= {fall_dat, sr[9:1]};
            bit_cnt <= 4'd1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (fall) begin
            timer <= '0;
            if (bit_cnt == 4'd10) begin
              if (!full[0] && (^full[9:1]) && full[10]) begin
                byte_stb  <= 1'b1;
                byte_data <= full[8:1];
              end else begin
                rx_err <= 1'b1;
              end
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              sr      <= {fall_dat, sr[9:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_err  <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-source keys: {hit, row*5+col}. CS/SS and Backspace are handled as tracked sources.
  function automatic logic [6:0] key_slot(input logic [7:0] code);
    case (code)
      8'h1A: key_slot = {1'b1, 6'd1};   8'h22: key_slot = {1'b1, 6'd2};
      8'h21: key_slot = {1'b1, 6'd3};   8'h2A: key_slot = {1'b1, 6'd4};
      8'h1C: key_slot = {1'b1, 6'd5};   8'h1B: key_slot = {1'b1, 6'd6};
      8'h23: key_slot = {1'b1, 6'd7};   8'h2B: key_slot = {1'b1, 6'd8};
      8'h34: key_slot = {1'b1, 6'd9};   8'h15: key_slot = {1'b1, 6'd10};
      8'h1D: key_slot = {1'b1, 6'd11};  8'h24: key_slot = {1'b1, 6'd12};
      8'h2D: key_slot = {1'b1, 6'd13};  8'h2C: key_slot = {1'b1, 6'd14};
      8'h16: key_slot = {1'b1, 6'd15};  8'h1E: key_slot = {1'b1, 6'd16};
      8'h26: key_slot = {1'b1, 6'd17};  8'h25: key_slot = {1'b1, 6'd18};
      8'h2E: key_slot = {1'b1, 6'd19};  8'h45: key_slot = {1'b1, 6'd20};
      8'h46: key_slot = {1'b1, 6'd21};  8'h3E: key_slot = {1'b1, 6'd22};
      8'h3D: key_slot = {1'b1, 6'd23};  8'h36: key_slot = {1'b1, 6'd24};
      8'h4D: key_slot = {1'b1, 6'd25};  8'h44: key_slot = {1'b1, 6'd26};
      8'h43: key_slot = {1'b1, 6'd27};  8'h3C: key_slot = {1'b1, 6'd28};
      8'h35: key_slot = {1'b1, 6'd29};  8'h5A: key_slot = {1'b1, 6'd30};
      8'h4B: key_slot = {1'b1, 6'd31};  8'h42: key_slot = {1'b1, 6'd32};
      8'h3B: key_slot = {1'b1, 6'd33};  8'h33: key_slot = {1'b1, 6'd34};
      8'h29: key_slot = {1'b1, 6'd35};  8'h3A: key_slot = {1'b1, 6'd37};
      8'h31: key_slot = {1'b1, 6'd38};  8'h32: key_slot = {1'b1, 6'd39};
      default: key_slot = 7'd0;
    endcase
  endfunction

  assign slot = key_slot(byte_data);

  always_ff @(posedge clk28) begin
    if (rst) begin
      ext <= 1'b0; brk <= 1'b0;
      key_m <= '0;
      lshift <= 1'b0; rshift <= 1'b0; bksp <= 1'b0;
      alt_l <= 1'b0; alt_r <= 1'b0; ctrl_l <= 1'b0; ctrl_r <= 1'b0;
      joy_up <= 1'b0; joy_down <= 1'b0; joy_left <= 1'b0; joy_right <= 1'b0;
      key_magic <= 1'b0; key_reset <= 1'b0; frame_err <= 1'b0;
    end else begin
      key_magic <= 1'b0;
      key_reset <= 1'b0;
      frame_err <= rx_err;
      if (byte_stb) begin
        if (byte_data == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (byte_data == 8'h00 || byte_data == 8'hFF) begin
            key_m <= '0;
            lshift <= 1'b0; rshift <= 1'b0; bksp <= 1'b0;
            alt_l <= 1'b0; alt_r <= 1'b0; ctrl_l <= 1'b0; ctrl_r <= 1'b0;
            joy_up <= 1'b0; joy_down <= 1'b0; joy_left <= 1'b0; joy_right <= 1'b0;
          end else if (!ext) begin
            case (byte_data)
              8'h12: lshift    <= !brk;
              8'h59: rshift    <= !brk;
              8'h66: bksp      <= !brk;
              8'h11: alt_l     <= !brk;
              8'h14: ctrl_l    <= !brk;
              8'h07: key_magic <= !brk;
              default: if (slot[6]) key_m[slot[5:0]] <= !brk;
            endcase
          end else begin
            case (byte_data)
              8'h11: alt_r     <= !brk;
              8'h14: ctrl_r    <= !brk;
              8'h75: joy_up    <= !brk;
              8'h72: joy_down  <= !brk;
              8'h6B: joy_left  <= !brk;
              8'h74: joy_right <= !brk;
              8'h71: key_reset <= !brk && (ctrl_l || ctrl_r) && (alt_l || alt_r);
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Slot 0 = CS, 20 = key 0, 36 = SS; each ORs every PC source that drives it.
  always_comb begin
    pressed     = key_m;
    pressed[0]  = key_m[0] | lshift | rshift | bksp;
    pressed[20] = key_m[20] | bksp;
    pressed[36] = key_m[36] | alt_l | alt_r;
    col_hit     = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!addr_hi[r] && pressed[r*5+c]) col_hit[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) kd <= 5'b11111;
    else     kd <= ~col_hit;
  end

  assign kempston_data = {3'b000, ctrl_l, joy_up, joy_down, joy_left, joy_right};

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: PS/2 frame driver, key-state reference model,
// pulse scoreboard and level checks of kd/kempston_data.
module tb_ps2_zx_keyboard;

  localparam int HALF = 10;
  localparam logic [1:0] EV_ERR = 2'd0, EV_MAGIC = 2'd1, EV_RESET = 2'd2;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_dat;
  logic [7:0] addr_hi;
  logic [4:0] kd;
  logic [7:0] kempston_data;
  logic       key_magic, key_reset, frame_err;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  // Reference model: set of held PC keys indexed by {ext, code}
  bit   key_down [0:511];
  bit   m_ext, m_brk;
  logic [7:0] tbl [8][5] = '{
    '{8'h00, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h00, 8'h3A, 8'h31, 8'h32}
  };

  ps2_zx_keyboard dut (
    .clk28(clk28), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .addr_hi(addr_hi), .kd(kd), .kempston_data(kempston_data),
    .key_magic(key_magic), .key_reset(key_reset), .frame_err(frame_err)
  );

  always #5 clk28 = ~clk28;

  function automatic bit model_pressed(input int r, input int c);
    bit p;
    p = (tbl[r][c] != 8'h00) && key_down[{1'b0, tbl[r][c]}];
    if (r == 0 && c == 0) p = key_down[9'h012] | key_down[9'h059] | key_down[9'h066];
    if (r == 4 && c == 0) p = p | key_down[9'h066];
    if (r == 7 && c == 1) p = key_down[9'h011] | key_down[9'h111];
    return p;
  endfunction

  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [4:0] k;
    k = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && model_pressed(r, c)) k[c] = 1'b0;
    return k;
  endfunction

  function automatic logic [7:0] model_kemp();
    return {3'b000, key_down[9'h014], key_down[9'h175], key_down[9'h172],
            key_down[9'h16B], key_down[9'h174]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) key_down[i] = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ctrl, alt;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      ctrl = key_down[9'h014] | key_down[9'h114];
      alt  = key_down[9'h011] | key_down[9'h111];
      if (b == 8'h00 || b == 8'hFF) model_clear();
      else begin
        if (!m_ext && b == 8'h07 && !m_brk) exp_q.push_back(EV_MAGIC);
        if (m_ext && b == 8'h71 && !m_brk && ctrl && alt) exp_q.push_back(EV_RESET);
        key_down[{m_ext, b}] = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(posedge clk28);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk28);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (HALF) @(posedge clk28);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad);
    return {1'b1, (~^d) ^ bad, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits(mk_frame(b, 1'b0), 11);
    repeat (20) @(posedge clk28);
  endtask

  task automatic send_key(input logic [8:0] k, input bit release_key);
    if (k[8]) send_byte(8'hE0);
    if (release_key) send_byte(8'hF0);
    send_byte(k[7:0]);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_q.push_back(EV_ERR);
    send_bits(mk_frame(b, 1'b1), 11);
    repeat (20) @(posedge clk28);
  endtask

  task automatic check_kd(input string name, input logic [7:0] a, input logic [4:0] want);
    addr_hi = a;
    repeat (3) @(posedge clk28);
    @(negedge clk28);
    checks++;
    if (kd !== want) begin
      failures++;
      $display("FAIL %s addr_hi=%h kd=%b expected=%b", name, a, kd, want);
    end
  endtask

  task automatic check_kemp(input string name, input logic [7:0] want);
    @(negedge clk28);
    checks++;
    if (kempston_data !== want) begin
      failures++;
      $display("FAIL %s kempston_data=%h expected=%h", name, kempston_data, want);
    end
  endtask

  task automatic check_state(input string name);
    logic [7:0] a;
    a = 8'(~(8'd1 << $urandom_range(0, 7)));
    check_kd(name, a, model_kd(a));
    a = 8'($urandom_range(0, 255));
    check_kd(name, a, model_kd(a));
    check_kd(name, 8'h00, model_kd(8'h00));
    check_kemp(name, model_kemp());
  endtask

  task automatic pop_event(input logic [1:0] ev, input string name);
    logic [1:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL pulse_%s unexpected pulse, expected none", name);
    end else begin
      want = exp_q.pop_front();
      if (want !== ev) begin
        failures++;
        $display("FAIL pulse_%s got event %0d expected event %0d", name, ev, want);
      end
    end
  endtask

  // Monitor: every sampled pulse cycle consumes one expected event
  always @(negedge clk28) begin
    if (!rst) begin
      if (frame_err) pop_event(EV_ERR, "frame_err");
      if (key_magic) pop_event(EV_MAGIC, "key_magic");
      if (key_reset) pop_event(EV_RESET, "key_reset");
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk28);
    rst = 1'b0;
    model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  logic [8:0] pool [22] = '{9'h012, 9'h059, 9'h066, 9'h011, 9'h111, 9'h014, 9'h114,
                            9'h175, 9'h172, 9'h16B, 9'h174, 9'h01A, 9'h01C, 9'h045,
                            9'h029, 9'h03A, 9'h05A, 9'h036, 9'h007, 9'h171, 9'h0AA,
                            9'h05B};

  initial begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    addr_hi = 8'hFF;
    do_reset();

    check_kd("reset_kd", 8'h00, 5'b11111);
    check_kemp("reset_kemp", 8'h00);

    // A key on row 1
    send_key(9'h01C, 1'b0);
    check_kd("a_make", 8'hFD, 5'b11110);
    check_kd("a_unselected", 8'hFF, 5'b11111);
    send_key(9'h01C, 1'b1);
    check_kd("a_break", 8'hFD, 5'b11111);

    // Shift + Z
    send_key(9'h012, 1'b0);
    send_key(9'h01A, 1'b0);
    check_kd("cs_z", 8'hFE, 5'b11100);
    send_key(9'h012, 1'b1);
    check_kd("z_only", 8'hFE, 5'b11101);
    send_key(9'h01A, 1'b1);

    // Bad parity dropped, next good frame accepted
    send_bad(8'h1C);
    check_kd("bad_parity", 8'hFD, 5'b11111);
    send_key(9'h01C, 1'b0);
    check_kd("after_bad", 8'hFD, 5'b11110);
    send_key(9'h01C, 1'b1);

    // Kempston
    send_key(9'h175, 1'b0);
    check_kemp("kemp_up", 8'h08);
    send_key(9'h16B, 1'b0);
    check_kemp("kemp_up_left", 8'h0A);
    send_key(9'h175, 1'b1);
    check_kemp("kemp_left", 8'h02);
    send_key(9'h014, 1'b0);
    check_kemp("kemp_fire_left", 8'h12);

    // Backspace and 0 share the key-0 bit
    send_key(9'h066, 1'b0);
    send_key(9'h045, 1'b0);
    send_key(9'h066, 1'b1);
    check_kd("bksp_0_held", 8'hEF, 5'b11110);
    check_kd("bksp_cs_clear", 8'hFE, 5'b11111);
    send_key(9'h045, 1'b1);

    // Stall mid-frame: timeout
    exp_q.push_back(EV_ERR);
    send_bits(mk_frame(8'h1C, 1'b0), 5);
    repeat (30000) @(posedge clk28);
    send_key(9'h01C, 1'b0);
    check_kd("after_timeout", 8'hFD, 5'b11110);

    // Hotkeys and overflow
    send_key(9'h011, 1'b0);
    send_key(9'h171, 1'b0);
    send_key(9'h007, 1'b0);
    send_key(9'h007, 1'b1);
    send_byte(8'hFF);
    check_kd("overflow_kd", 8'h00, 5'b11111);
    check_kemp("overflow_kemp", 8'h00);

    // Reset mid-frame aborts silently
    send_key(9'h01C, 1'b0);
    send_bits(mk_frame(8'h1A, 1'b0), 3);
    do_reset();
    check_kd("mid_reset", 8'h00, 5'b11111);
    send_key(9'h01A, 1'b0);
    check_kd("post_reset_frame", 8'hFE, 5'b11101);

    // Randomised key traffic
    for (int it = 0; it < 45; it++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (pick < 6) send_bad(8'($urandom_range(0, 255)));
      else if (pick < 9) send_byte(8'hFF);
      else send_key(pool[$urandom_range(0, 21)], $urandom_range(0, 9) < 4);
      check_state("random");
    end

    repeat (50) @(posedge clk28);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
